axi_write_joiner: RTL
=====================

Name: axi_write_joiner

Overview:
- Sits directly downstream of the AW address counter.
- Pairs each per-beat address from that stage with the matching AXI W-channel beat and issues one registered write to the local register/BRAM port.
- Generates one B-channel response per completed burst, tracked by an outstanding-response counter that backpressures W when full.

Parameters:
- ADDR_WIDTH, 12, address width; must match the address counter.
- DATA_WIDTH, 32, W data width; strobe width is DATA_WIDTH/8.
- MAX_OUTSTANDING_B, 4, maximum completed bursts awaiting a B handshake; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_addr_data  in  ADDR_WIDTH  per-beat byte address from the address counter
- i_addr_valid  in  1  address beat valid
- i_addr_ready  out  1  address beat accepted
- i_wdata  in  DATA_WIDTH  AXI W data
- i_wstrb  in  DATA_WIDTH/8  AXI W byte strobes
- i_wlast  in  1  AXI W last beat of burst
- i_wvalid  in  1  AXI W valid
- i_wready  out  1  AXI W ready
- o_wr_en  out  1  single-cycle write strobe to memory
- o_wr_addr  out  ADDR_WIDTH  write byte address
- o_wr_data  out  DATA_WIDTH  write data
- o_wr_strb  out  DATA_WIDTH/8  write byte enables
- o_bresp  out  2  AXI B response
- o_bvalid  out  1  AXI B valid
- i_bready  in  1  AXI B ready

Behaviour:
- Reset: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_wr_strb=0, b_count=0, o_bvalid=0. Reset overrides all same-cycle events, including a mid-burst join or a pending B. Pending responses are discarded.
- b_count width: $clog2(MAX_OUTSTANDING_B+1).
- can_accept = (b_count < MAX_OUTSTANDING_B).
- Combinational readies:
  - i_addr_ready = i_wvalid && can_accept
  - i_wready = i_addr_valid && can_accept
- join = i_addr_valid && i_wvalid && can_accept. Address and W beats are consumed together, never one without the other.
- Write port, 1-cycle latency:
  - On the clock edge where join=1: o_wr_en<=1, o_wr_addr<=i_addr_data, o_wr_data<=i_wdata, o_wr_strb<=i_wstrb.
  - Otherwise o_wr_en<=0; addr/data/strb hold their last values.
  - The memory always accepts writes; the write port has no ready.
- B counter:
  - inc = join && i_wlast
  - dec = o_bvalid && i_bready
  - inc && !dec: +1. dec && !inc: -1. Both: unchanged. Neither: unchanged.
- o_bvalid = (b_count != 0). The first B for a burst becomes visible in the same cycle its last o_wr_en is asserted, never earlier.
- o_bresp = 2'b00 (OKAY) always; no SLVERR/DECERR generation.
- Full boundary:
  - At b_count==MAX_OUTSTANDING_B, both readies are 0, even if i_bready=1 this cycle. No same-cycle pass-through, so ready does not depend on i_bready.
  - Acceptance resumes the cycle after the decrement.
- Empty boundary: at b_count==0, o_bvalid=0 and i_bready is ignored; no underflow.
- WLAST handling: i_wlast is trusted. Each burst's beat count matching awlen+1 is the upstream counter's responsibility. A stray early wlast still increments b_count.
- Invariants (formal):
  - b_count ≤ MAX_OUTSTANDING_B.
  - o_wr_en implies $past(join).
  - While o_bvalid && !i_bready, o_bvalid stays high and o_bresp is stable.
  - Inputs held stable under stall are assumed in the _FORMAL define, asserted otherwise.

Test Plan:
- Reset, then single-beat burst: addr=0x010, wdata=0xDEADBEEF, wstrb=0xF, wlast=1 → next cycle o_wr_en=1, o_wr_addr=0x010, o_wr_data=0xDEADBEEF; o_bvalid=1 with o_bresp=0; bready=1 → o_bvalid=0 next cycle.
- 4-beat burst from 0x100, addr and W both valid every cycle → o_wr_en on 4 consecutive cycles at 0x100/0x104/0x108/0x10C; exactly one B, asserted with the 4th write.
- Skew: W valid 3 cycles before the first address, then addresses arrive with 2-cycle gaps → no o_wr_en until each address arrives; i_wready stays 0 while i_addr_valid=0; data is paired in order.
- B backpressure: i_bready=0, 5 single-beat bursts with MAX_OUTSTANDING_B=4 → 4 writes issue, then i_wready=i_addr_ready=0; raise i_bready for 1 cycle → b_count=3 and the 5th beat is accepted the following cycle.
- Simultaneous events: b_count=2, a wlast join in the same cycle as a B handshake → b_count stays 2, o_bvalid stays 1.
- Reset mid-burst: after 2 of 4 beats with 1 B pending, assert reset for 1 cycle → o_wr_en=0, o_bvalid=0, b_count=0; a new burst afterwards completes normally.

Source files
------------

// File: rtl/axi_write_joiner_if.sv
// Bundle between the AW address counter / W channel / B channel and the
// local write port of axi_write_joiner.
interface axi_write_joiner_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] i_addr_data;
  logic                  i_addr_valid;
  logic                  i_addr_ready;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [STRB_WIDTH-1:0] i_wstrb;
  logic                  i_wlast;
  logic                  i_wvalid;
  logic                  i_wready;
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic [STRB_WIDTH-1:0] o_wr_strb;
  logic [1:0]            o_bresp;
  logic                  o_bvalid;
  logic                  i_bready;

  modport slave (
    input  i_addr_data, i_addr_valid, i_wdata, i_wstrb, i_wlast, i_wvalid, i_bready,
    output i_addr_ready, i_wready, o_wr_en, o_wr_addr, o_wr_data, o_wr_strb,
           o_bresp, o_bvalid
  );

  modport master (
    output i_addr_data, i_addr_valid, i_wdata, i_wstrb, i_wlast, i_wvalid, i_bready,
    input  i_addr_ready, i_wready, o_wr_en, o_wr_addr, o_wr_data, o_wr_strb,
           o_bresp, o_bvalid
  );
endinterface

// File: rtl/axi_write_joiner.sv
// Joins per-beat addresses with AXI W beats into registered memory writes and
// returns one OKAY B response per burst, bounded by an outstanding counter.
module axi_write_joiner #(
  parameter int ADDR_WIDTH        = 12,
  parameter int DATA_WIDTH        = 32,
  parameter int MAX_OUTSTANDING_B = 4
) (
  input logic               clk,
  input logic               reset,
  axi_write_joiner_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(MAX_OUTSTANDING_B + 1);
  localparam logic [CNT_WIDTH-1:0] B_MAX = CNT_WIDTH'(MAX_OUTSTANDING_B);
  localparam logic [CNT_WIDTH-1:0] B_ONE = CNT_WIDTH'(1);

  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;
  logic [CNT_WIDTH-1:0]  b_count_q, b_count_d;

  logic can_accept_s;
  logic join_s;
  logic inc_s;
  logic dec_s;

  // Join decision, write-port next state and B counter next state.
  always_comb begin
    can_accept_s = (b_count_q < B_MAX);
    join_s       = bus.i_addr_valid && bus.i_wvalid && can_accept_s;
    inc_s        = join_s && bus.i_wlast;
    dec_s        = (b_count_q != '0) && bus.i_bready;

    wr_en_d = join_s;
    if (join_s) begin
      wr_addr_d = bus.i_addr_data;
      wr_data_d = bus.i_wdata;
      wr_strb_d = bus.i_wstrb;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_strb_d = wr_strb_q;
    end

    // A burst completing while a B drains leaves the count untouched.
    case ({inc_s, dec_s})
      2'b10:   b_count_d = b_count_q + B_ONE;
      2'b01:   b_count_d = b_count_q - B_ONE;
      default: b_count_d = b_count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      b_count_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      b_count_q <= b_count_d;
    end
  end

  // Readies never look at i_bready, so a full counter always stalls a cycle.
  assign bus.i_addr_ready = bus.i_wvalid && can_accept_s;
  assign bus.i_wready     = bus.i_addr_valid && can_accept_s;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_wr_strb    = wr_strb_q;
  assign bus.o_bvalid     = (b_count_q != '0);
  assign bus.o_bresp      = 2'b00;

`ifndef SYNTHESIS
  axi_write_joiner_chk #(
    .ADDR_WIDTH        (ADDR_WIDTH),
    .DATA_WIDTH        (DATA_WIDTH),
    .MAX_OUTSTANDING_B (MAX_OUTSTANDING_B),
    .CNT_WIDTH         (CNT_WIDTH)
  ) u_chk (
    .clk          (clk),
    .reset        (reset),
    .b_count      (b_count_q),
    .join_s       (join_s),
    .i_addr_data  (bus.i_addr_data),
    .i_addr_valid (bus.i_addr_valid),
    .i_addr_ready (bus.i_addr_ready),
    .i_wdata      (bus.i_wdata),
    .i_wstrb      (bus.i_wstrb),
    .i_wlast      (bus.i_wlast),
    .i_wvalid     (bus.i_wvalid),
    .i_wready     (bus.i_wready),
    .o_wr_en      (bus.o_wr_en),
    .o_bvalid     (bus.o_bvalid),
    .o_bresp      (bus.o_bresp),
    .i_bready     (bus.i_bready)
  );
`endif
endmodule

// Protocol and invariant checks for axi_write_joiner; input stability is an
// assumption under _FORMAL and a checked property otherwise.
module axi_write_joiner_chk #(
  parameter int ADDR_WIDTH        = 12,
  parameter int DATA_WIDTH        = 32,
  parameter int MAX_OUTSTANDING_B = 4,
  parameter int CNT_WIDTH         = 3
) (
  input logic                    clk,
  input logic                    reset,
  input logic [CNT_WIDTH-1:0]    b_count,
  input logic                    join_s,
  input logic [ADDR_WIDTH-1:0]   i_addr_data,
  input logic                    i_addr_valid,
  input logic                    i_addr_ready,
  input logic [DATA_WIDTH-1:0]   i_wdata,
  input logic [DATA_WIDTH/8-1:0] i_wstrb,
  input logic                    i_wlast,
  input logic                    i_wvalid,
  input logic                    i_wready,
  input logic                    o_wr_en,
  input logic                    o_bvalid,
  input logic [1:0]              o_bresp,
  input logic                    i_bready
);
  a_count_max: assert property (@(posedge clk) disable iff (reset)
    b_count <= CNT_WIDTH'(MAX_OUTSTANDING_B))
    else $error("b_count above limit");

  a_wr_from_join: assert property (@(posedge clk) disable iff (reset)
    o_wr_en |-> $past(join_s))
    else $error("write strobe without join");

  a_b_hold: assert property (@(posedge clk) disable iff (reset)
    (o_bvalid && !i_bready) |=> (o_bvalid && $stable(o_bresp)))
    else $error("B response dropped under stall");

  property p_addr_hold;
    @(posedge clk) disable iff (reset)
      (i_addr_valid && !i_addr_ready) |=> (i_addr_valid && $stable(i_addr_data));
  endproperty

  property p_w_hold;
    @(posedge clk) disable iff (reset)
      (i_wvalid && !i_wready) |=> (i_wvalid && $stable({i_wdata, i_wstrb, i_wlast}));
  endproperty

`ifdef _FORMAL
  m_addr_hold: assume property (p_addr_hold);
  m_w_hold:    assume property (p_w_hold);
`else
  a_addr_hold: assert property (p_addr_hold) else $error("address changed under stall");
  a_w_hold:    assert property (p_w_hold) else $error("W beat changed under stall");
`endif
endmodule
